// File: rtl/mem_word_arbiter.sv
// mem_word_arbiter: shares one byte-wide memory between fetch and data ports as 4-byte big-endian words.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data priority.
module mem_word_arbiter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;
  state_t            state_q;
  logic [1:0]        cnt_q;
  logic              own_dm_q, we_q, if_ack_q, dm_ack_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q, asm_q, if_rdata_q, dm_rdata_q;
  logic              gnt_dm_d;
  logic [31:0]       asm_d;
`ifdef MEM_ARB_RR_EN
  logic              last_dm_q;
  assign gnt_dm_d = dm_req && (!if_req || !last_dm_q);
`else
  assign gnt_dm_d = dm_req;
`endif
  assign asm_d = {asm_q[23:0], mem_rdata};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      own_dm_q   <= 1'b0;
      we_q       <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_dm_q  <= 1'b0;
`endif
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        IDLE: if (if_req || dm_req) begin
          state_q  <= XFER;
          cnt_q    <= '0;
          own_dm_q <= gnt_dm_d;
          we_q     <= gnt_dm_d && dm_we;
          base_q   <= gnt_dm_d ? dm_addr : if_addr;
          wdata_q  <= dm_wdata;
`ifdef MEM_ARB_RR_EN
          last_dm_q <= gnt_dm_d;
`endif
        end
        XFER: begin
          if (!we_q) asm_q <= asm_d;
          wdata_q <= wdata_q << 8;
          // cnt stays at 3 afterwards so mem_addr keeps the last byte address
          if (cnt_q == 2'd3) begin
            state_q <= ACK;
            if (own_dm_q) begin
              dm_ack_q <= 1'b1;
              if (!we_q) dm_rdata_q <= asm_d;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= asm_d;
            end
          end else cnt_q <= cnt_q + 2'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_addr  = base_q + ADDR_W'(cnt_q);
  assign mem_we    = (state_q == XFER) && we_q;
  assign mem_wdata = wdata_q[31:24];
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_word_arbiter.sv
// tb_mem_word_arbiter: directed scoreboard bench for mem_word_arbiter with a byte memory model.
module tb_mem_word_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req = 1'b0, if_ack, dm_req = 1'b0, dm_we = 1'b0, dm_ack;
  logic [4:0]  if_addr = '0, dm_addr = '0, mem_addr;
  logic [31:0] if_rdata, dm_rdata, dm_wdata = '0;
  logic        mem_we, busy;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  mem [32] = '{default: 8'h55};
  logic        poke_en = 1'b0;
  logic [4:0]  poke_addr = '0;
  logic [7:0]  poke_data = '0;
  logic [31:0] if_exp[$], dm_exp[$];
  logic [4:0]  seq [4];
  int          n_chk = 0, n_fail = 0, lat, wecnt, t_dm, t_if;
  logic        hold_bad;

  mem_word_arbiter #(.ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every ack pops the expected word for that port
  always @(negedge clk) if (rst_n) begin
    if (if_ack) begin
      if (if_exp.size() == 0) chk("if_ack_unexpected", 96'd1, 96'd0);
      else chk("if_rdata", {64'd0, if_rdata}, {64'd0, if_exp.pop_front()});
    end
    if (dm_ack) begin
      if (dm_exp.size() == 0) chk("dm_ack_unexpected", 96'd1, 96'd0);
      else chk("dm_rdata", {64'd0, dm_rdata}, {64'd0, dm_exp.pop_front()});
    end
  end

  task automatic poke4(input logic [4:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      poke_en = 1'b1; poke_addr = a + 5'(i); poke_data = w[31-8*i -: 8];
    end
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic run(input bit dm, input bit we, input logic [4:0] a,
                     input logic [31:0] wd, input logic [31:0] exp);
    if (dm) dm_exp.push_back(exp); else if_exp.push_back(exp);
    @(negedge clk);
    if (dm) begin dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; end
    else begin if_req = 1'b1; if_addr = a; end
    lat = 0; wecnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n <= 4) seq[n-1] = mem_addr;
      if (mem_we) wecnt++;
      if (dm ? dm_ack : if_ack) begin lat = n; break; end
    end
    if (dm) dm_req = 1'b0; else if_req = 1'b0;
    chk("latency", 96'(lat), 96'd5);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", 96'({busy, mem_we, if_ack, dm_ack, mem_addr, mem_wdata, if_rdata, dm_rdata}), 96'd0);
    rst_n = 1'b1;
    poke4(5'd0, 32'h8CA20004);
    run(1'b0, 1'b0, 5'd0, 32'h0, 32'h8CA20004);
    chk("fetch_no_write", 96'(wecnt), 96'd0);
    run(1'b1, 1'b1, 5'd8, 32'hDEADBEEF, 32'h0);
    chk("store_bytes", 96'({mem[8], mem[9], mem[10], mem[11]}), 96'h0DEADBEEF);
    run(1'b1, 1'b0, 5'd8, 32'h0, 32'hDEADBEEF);
    poke4(5'd30, 32'h11223344);
    run(1'b1, 1'b0, 5'd30, 32'h0, 32'h11223344);
    chk("wrap_addr_seq", 96'({seq[0], seq[1], seq[2], seq[3]}), 96'({5'd30, 5'd31, 5'd0, 5'd1}));
    // hold: fetch held high for two words, rdata must stay put between acks
    poke4(5'd4, 32'h01020304);
    if_exp.push_back(32'h01020304); if_exp.push_back(32'h01020304);
    @(negedge clk);
    if_req = 1'b1; if_addr = 5'd4;
    t_if = 0; t_dm = 0; hold_bad = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (t_dm != 0 && !if_ack && if_rdata !== 32'h01020304) hold_bad = 1'b1;
      if (if_ack && t_dm == 0) t_dm = n;
      else if (if_ack) begin t_if = n; break; end
    end
    if_req = 1'b0;
    chk("hold_first_ack", 96'(t_dm), 96'd5);
    chk("hold_spacing", 96'(t_if - t_dm), 96'd6);
    chk("hold_stable", 96'(hold_bad), 96'd0);
    // contention: both rise together, data owns the first word
    dm_exp.push_back(32'hDEADBEEF); if_exp.push_back(32'h33440004);
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 5'd8; if_req = 1'b1; if_addr = 5'd0;
    t_dm = 0; t_if = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (dm_ack) begin t_dm = n; dm_req = 1'b0; end
      if (if_ack) begin t_if = n; if_req = 1'b0; end
      if (t_dm != 0 && t_if != 0) break;
    end
    dm_req = 1'b0; if_req = 1'b0;
    chk("contend_dm_ack", 96'(t_dm), 96'd5);
    chk("contend_if_ack", 96'(t_if), 96'd11);
    // reset asserted after two store bytes have been written
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 5'd16; dm_wdata = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    #1;
    chk("reset_mid_outputs", 96'({busy, mem_we, if_ack, dm_ack, mem_addr, mem_wdata, if_rdata, dm_rdata}), 96'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("reset_mid_bytes", 96'({mem[16], mem[17], mem[18], mem[19]}), 96'h0DEAD5555);
    chk("scoreboard_empty", 96'(if_exp.size() + dm_exp.size()), 96'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_word_arbiter.md
# mem_word_arbiter

Shares one byte-wide, single-ported memory between the instruction-fetch requester and the data load/store requester of the processor. Each granted request becomes a four-cycle big-endian byte sequence: byte at `addr` maps to bits 31:24, and `addr+3` maps to bits 7:0. The block sits between the fetch/datapath logic and a unified 32-entry byte memory, and replaces separate instruction and data memory ports.

## Interface
Parameters:
- `ADDR_W`, default 5: byte address width. Memory depth is 2^ADDR_W.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  fetch request; held high until `if_ack`.
- `if_addr`  in  ADDR_W  fetch byte address; stable while `if_req` is high.
- `if_rdata`  out  32  fetched word; valid while `if_ack` is high.
- `if_ack`  out  1  one-cycle completion pulse for fetch.
- `dm_req`  in  1  data request; held high until `dm_ack`.
- `dm_we`  in  1  1 = store, 0 = load; stable while `dm_req` is high.
- `dm_addr`  in  ADDR_W  data byte address.
- `dm_wdata`  in  32  store data.
- `dm_rdata`  out  32  load word; valid while `dm_ack` is high.
- `dm_ack`  out  1  one-cycle completion pulse for data.
- `mem_addr`  out  ADDR_W  byte address to memory.
- `mem_we`  out  1  byte write strobe; memory writes on the `clk` rising edge.
- `mem_wdata`  out  8  byte to write.
- `mem_rdata`  in  8  combinational read of `mem_addr`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states and transitions:
  - IDLE: if any request is pending, go to XFER. Arbitration picks the owner; the owner's address, `we` and `wdata` are latched and `cnt` is set to 0.
  - XFER: performs byte `cnt`, then increments `cnt`. Goes to ACK after `cnt==3`.
  - ACK: pulses the owner's ack for one cycle, then goes to IDLE unconditionally.
- Byte address: `mem_addr = (base + cnt) mod 2^ADDR_W`.
  - Misaligned bases are legal.
  - Wrap-around is allowed: base 30 accesses bytes 30, 31, 0, 1.
- Load: in XFER, `mem_rdata` is shifted into a 32-bit assembly register as `{asm[23:0], mem_rdata}`. The result appears on the owner's rdata in ACK.
- Store: in XFER, `mem_we=1` and `mem_wdata = wdata[31-8*cnt -: 8]`. The assembly register is not updated. The owner's rdata in ACK is undefined-but-stable (drive the last held value).
- Fetch requests never write: `mem_we=0` for a fetch owner regardless of other inputs.
- Arbitration in IDLE (fixed priority):
  - If only one request is pending, that requester wins.
  - If both are pending, data wins.
- Outside XFER: `mem_we=0` and `mem_addr` holds its last value.
- Requester rule: the requester deasserts or changes `req` on the same edge at which it samples ack=1. A request still high in IDLE after ACK is treated as new.
- `if_rdata` and `dm_rdata` hold their value after ack until the next completion for that port.

## Timing
- Reset (asynchronous): state=IDLE, `cnt=0`, all outputs 0, `last_grant` = fetch.
- Latency: request high at IDLE edge E0 → XFER bytes at E1..E4 → ack high during the cycle after E4, sampled at E5.
- A back-to-back word takes 6 cycles: IDLE, XFER×4, ACK.
- A request arriving during XFER or ACK waits. It is evaluated at the next IDLE edge.
- Simultaneous request rise: resolved by arbitration. The loser's inputs are ignored until its grant.
- Reset asserted mid-XFER: the transfer is aborted and no ack is issued. Bytes already written remain in memory. `mem_we` drops immediately and asynchronously.
- `busy` = (state != IDLE). It is registered and has no combinational path from `req`.

## Configuration
- `MEM_ARB_RR_EN`:
  - Defined: round-robin arbitration. When both requests are pending in IDLE, grant goes to the port that was not `last_grant`. `last_grant` updates on every grant.
  - Undefined: fixed data priority. `last_grant` logic is compiled out.

## Test plan
- Fetch load: memory bytes 0..3 = 8C,A2,00,04; `if_req` with `if_addr=0`. Required: `if_ack` at cycle 5 with `if_rdata=8CA20004`, and `mem_we` stays 0 throughout.
- Data store then load: `dm_we=1`, `dm_addr=8`, `dm_wdata=DEADBEEF`. Required: bytes 8..11 = DE,AD,BE,EF. A following load from 8 returns DEADBEEF 6 cycles later.
- Wrap: load from `dm_addr=30` with bytes 30,31,0,1 = 11,22,33,44. Required: `mem_addr` sequence 30,31,0,1 and `dm_rdata=11223344`.
- Contention: `if_req` and `dm_req` rise on the same edge, both held until ack.
  - Without the macro: `dm_ack` precedes `if_ack` by 6 cycles.
  - With `MEM_ARB_RR_EN` and both held continuously: grants alternate data, fetch, data, fetch.
- Reset mid-store: `rst_n` low after 2 XFER bytes of a `DEADBEEF` store to 16. Required: no `dm_ack`, bytes 16,17 = DE,AD, bytes 18,19 unchanged, and all outputs 0 during reset.
- Hold: with `if_req` held high, `if_rdata` is unchanged between acks.
